// File: rtl/mc_control_if.sv
// rtl/mc_control_if.sv - control/status bundle between mc_control and the RV64I datapath
//
// Purpose: groups the opcode/comparator/memory-handshake inputs and the
// enable/mux-select outputs of the multi-cycle sequencer.
// Ports (master = sequencer view):
//   in : opcode[6:0], branch_taken, mem_ready
//   out: mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src[1:0],
//        alu_src_a[1:0], alu_src_b[1:0], reg_we, wb_sel[1:0], illegal,
//        state[2:0], retired[CNT_W-1:0]
interface mc_control_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       opcode;
  logic             branch_taken;
  logic             mem_ready;
  logic             mem_req;
  logic             mem_we;
  logic             mem_addr_sel;
  logic             ir_we;
  logic             pc_we;
  logic [1:0]       pc_src;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic             reg_we;
  logic [1:0]       wb_sel;
  logic             illegal;
  logic [2:0]       state;
  logic [CNT_W-1:0] retired;

  modport master (
    input  opcode, branch_taken, mem_ready,
    output mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src,
           alu_src_a, alu_src_b, reg_we, wb_sel, illegal, state, retired
  );

  modport slave (
    output opcode, branch_taken, mem_ready,
    input  mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src,
           alu_src_a, alu_src_b, reg_we, wb_sel, illegal, state, retired
  );
endinterface

// File: rtl/mc_control.sv
// rtl/mc_control.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV64I core
//
// Purpose: steps each instruction through its phases, driving PC/IR/regfile
// enables, ALU operand selects and the shared memory port; counts retired
// instructions and halts (sticky illegal) on unsupported opcodes.
// Ports:
//   clk   - clock, all state on rising edge
//   reset - asynchronous, active-high
//   bus   - mc_control_if.master (see interface for signal list)
module mc_control #(
  parameter int CNT_W = 32
) (
  input  logic          clk,
  input  logic          reset,
  mc_control_if.master  bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    C_LOAD    = 4'd0,
    C_STORE   = 4'd1,
    C_OPIMM   = 4'd2,
    C_OPIMM32 = 4'd3,
    C_OP      = 4'd4,
    C_LUI     = 4'd5,
    C_AUIPC   = 4'd6,
    C_JAL     = 4'd7,
    C_JALR    = 4'd8,
    C_BRANCH  = 4'd9,
    C_ILLEGAL = 4'd10
  } class_t;

  state_t           state_q, state_d;
  class_t           class_q, class_d;
  class_t           dec_class;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire;
  logic [1:0]       sel_a, sel_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      class_q   <= C_LOAD;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      class_q   <= class_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    dec_class = C_ILLEGAL;
    case (bus.opcode)
      7'b0000011: dec_class = C_LOAD;
      7'b0100011: dec_class = C_STORE;
      7'b0010011: dec_class = C_OPIMM;
      7'b0011011: dec_class = C_OPIMM32;
      7'b0110011: dec_class = C_OP;
      7'b0110111: dec_class = C_LUI;
      7'b0010111: dec_class = C_AUIPC;
      7'b1101111: dec_class = C_JAL;
      7'b1100111: dec_class = C_JALR;
      7'b1100011: dec_class = C_BRANCH;
      default:    dec_class = C_ILLEGAL;
    endcase
  end

  // Operand selects depend only on the latched class, so EXEC, MEM and WB
  // present identical ALU inputs and the ALU result stays stable throughout.
  always_comb begin
    sel_a = 2'b00;
    sel_b = 2'b00;
    case (class_q)
      C_LOAD, C_STORE, C_OPIMM, C_OPIMM32, C_JALR: begin sel_a = 2'b00; sel_b = 2'b01; end
      C_LUI:                                      begin sel_a = 2'b10; sel_b = 2'b01; end
      C_AUIPC, C_JAL:                             begin sel_a = 2'b01; sel_b = 2'b01; end
      default:                                    begin sel_a = 2'b00; sel_b = 2'b00; end
    endcase
  end

  always_comb begin
    state_d          = state_q;
    class_d          = class_q;
    illegal_d        = illegal_q;
    retired_d        = retired_q;
    retire           = 1'b0;
    bus.mem_req      = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_addr_sel = 1'b0;
    bus.ir_we        = 1'b0;
    bus.pc_we        = 1'b0;
    bus.pc_src       = 2'b00;
    bus.alu_src_a    = 2'b00;
    bus.alu_src_b    = 2'b00;
    bus.reg_we       = 1'b0;
    bus.wb_sel       = 2'b00;

    case (state_q)
      S_FETCH: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ready) begin
          bus.ir_we = 1'b1;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        class_d = dec_class;
        if (dec_class == C_ILLEGAL) begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        bus.alu_src_a = sel_a;
        bus.alu_src_b = sel_b;
        case (class_q)
          C_BRANCH: begin
            bus.pc_we  = 1'b1;
            bus.pc_src = bus.branch_taken ? 2'b10 : 2'b00;
            retire     = 1'b1;
            state_d    = S_FETCH;
          end
          C_JAL, C_JALR: begin
            bus.reg_we = 1'b1;
            bus.wb_sel = 2'b10;
            bus.pc_we  = 1'b1;
            bus.pc_src = 2'b01;
            retire     = 1'b1;
            state_d    = S_FETCH;
          end
          C_LOAD, C_STORE: state_d = S_MEM;
          default:         state_d = S_WB;
        endcase
      end
      S_MEM: begin
        bus.alu_src_a    = sel_a;
        bus.alu_src_b    = sel_b;
        bus.mem_req      = 1'b1;
        bus.mem_addr_sel = 1'b1;
        bus.mem_we       = (class_q == C_STORE);
        if (bus.mem_ready) begin
          if (class_q == C_STORE) begin
            bus.pc_we = 1'b1;
            retire    = 1'b1;
            state_d   = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        bus.alu_src_a = sel_a;
        bus.alu_src_b = sel_b;
        bus.reg_we    = 1'b1;
        bus.wb_sel    = (class_q == C_LOAD) ? 2'b01 : 2'b00;
        bus.pc_we     = 1'b1;
        retire        = 1'b1;
        state_d       = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    if (retire) retired_d = retired_q + CNT_W'(1);

    // The state register already reads FETCH while reset is held; keep the
    // memory port and IR quiet until reset is released.
    if (reset) begin
      bus.mem_req = 1'b0;
      bus.ir_we   = 1'b0;
    end
  end

  assign bus.illegal = illegal_q;
  assign bus.state   = state_q;
  assign bus.retired = retired_q;

endmodule
